// File: rtl/pu_race_if.sv
`default_nettype none
// ============================================================================
// Module   : pu_race_if
// Brief    : Operand/result bundle between source, race engine and end-signal
//            generator.
// Revision : 1.0
// ============================================================================
interface pu_race_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic             end_signal;
    logic             PU0_zero;
    logic             PU1_zero;
    logic             PU2_zero;
    logic             PU3_zero;
    logic             busy;
    logic             done;
    logic [1:0]       winner;
    logic             tie;
    logic [WIDTH-1:0] steps;

    modport master (
        output start, in0, in1, in2, in3, end_signal,
        input  PU0_zero, PU1_zero, PU2_zero, PU3_zero,
        input  busy, done, winner, tie, steps
    );

    modport slave (
        input  start, in0, in1, in2, in3, end_signal,
        output PU0_zero, PU1_zero, PU2_zero, PU3_zero,
        output busy, done, winner, tie, steps
    );
endinterface
`default_nettype wire

// File: rtl/pu_race_engine.sv
`default_nettype none
// ============================================================================
// Module   : pu_race_engine
// Brief    : Four-lane countdown race; reports the last surviving lane or a tie.
// Revision : 1.0
// ============================================================================
module pu_race_engine #(
    parameter int WIDTH = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pu_race_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] lane_q [4];
    logic [WIDTH-1:0] lane_d [4];
    logic [3:0]       lane_zero;
    logic             busy_q;
    logic             done_q;
    logic [1:0]       winner_q;
    logic             tie_q;
    logic [WIDTH-1:0] steps_q;
    logic [1:0]       win_idx;

    // Zero lanes hold so a finished lane never wraps.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign lane_zero[g] = (lane_q[g] == '0);
        assign lane_d[g]    = lane_zero[g] ? lane_q[g] : (lane_q[g] - WIDTH'(1));
    end

    always_comb begin
        win_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!lane_zero[i]) begin
                win_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            winner_q <= 2'd0;
            tie_q    <= 1'b0;
            steps_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        lane_q[0] <= bus.in0;
                        lane_q[1] <= bus.in1;
                        lane_q[2] <= bus.in2;
                        lane_q[3] <= bus.in3;
                        steps_q   <= '0;
                        winner_q  <= 2'd0;
                        tie_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.end_signal) begin
                        winner_q <= win_idx;
                        tie_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (&lane_zero) begin
                        winner_q <= 2'd0;
                        tie_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            lane_q[i] <= lane_d[i];
                        end
                        steps_q <= steps_q + WIDTH'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.PU0_zero = lane_zero[0];
    assign bus.PU1_zero = lane_zero[1];
    assign bus.PU2_zero = lane_zero[2];
    assign bus.PU3_zero = lane_zero[3];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.winner   = winner_q;
    assign bus.tie      = tie_q;
    assign bus.steps    = steps_q;
endmodule
`default_nettype wire

// File: tb/tb_pu_race_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pu_race_engine
// Brief    : Closes the end-signal loop and checks race outcomes against a
//            max/second-max outcome model.
// Revision : 1.0
// ============================================================================
module tb_pu_race_engine;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pu_race_if #(.WIDTH(WIDTH)) bus ();

    pu_race_engine #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // End-signal generator: high when exactly one lane is still nonzero.
    assign bus.end_signal = ($countones({~bus.PU3_zero, ~bus.PU2_zero,
                                         ~bus.PU1_zero, ~bus.PU0_zero}) == 1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A race ends when the second-largest lane is exhausted: a unique maximum
    // wins after that many decrements, a shared maximum ties after max steps.
    task automatic ref_model(input logic [7:0] a0, a1, a2, a3,
                             output int st, output int w, output bit t,
                             output logic [3:0] flags);
        int v[4];
        int m1, cnt, idx, m2;
        v = '{int'(a0), int'(a1), int'(a2), int'(a3)};
        m1 = 0; idx = 0; cnt = 0; m2 = 0;
        for (int i = 0; i < 4; i++) if (v[i] > m1) begin m1 = v[i]; idx = i; end
        for (int i = 0; i < 4; i++) if (v[i] == m1) cnt++;
        for (int i = 0; i < 4; i++) if (i != idx && v[i] > m2) m2 = v[i];
        if (cnt >= 2) begin
            t = 1'b1; w = 0; st = m1; flags = 4'hF;
        end else begin
            t = 1'b0; w = idx; st = m2; flags = 4'hF & ~(4'h1 << idx);
        end
    endtask

    function automatic logic [3:0] zflags();
        return {bus.PU3_zero, bus.PU2_zero, bus.PU1_zero, bus.PU0_zero};
    endfunction

    task automatic run_case(input string tag, input logic [7:0] a0, a1, a2, a3);
        int st, w, cyc;
        bit t;
        logic [3:0] fl;
        ref_model(a0, a1, a2, a3, st, w, t, fl);
        bus.in0 = a0; bus.in1 = a1; bus.in2 = a2; bus.in3 = a3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.in0 = ~a0; bus.in1 = ~a1; bus.in2 = ~a2; bus.in3 = ~a3;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 600) begin
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            tick();
            cyc++;
        end
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(st + 2));
        chk({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        chk({tag, "_winner"}, 32'(bus.winner), 32'(w));
        chk({tag, "_tie"}, 32'(bus.tie), 32'(t));
        chk({tag, "_steps"}, 32'(bus.steps), 32'(st));
        chk({tag, "_flags"}, 32'(zflags()), 32'(fl));
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_hold_steps"}, 32'(bus.steps), 32'(st));
        chk({tag, "_hold_winner"}, 32'(bus.winner), 32'(w));
    endtask

    initial begin
        int cyc;
        logic [7:0] r[4];
        bus.start = 1'b0;
        bus.in0 = '0; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_winner", 32'(bus.winner), 32'd0);
        chk("rst_tie", 32'(bus.tie), 32'd0);
        chk("rst_steps", 32'(bus.steps), 32'd0);
        chk("rst_flags", 32'(zflags()), 32'hF);
        rst = 1'b0;
        tick();

        // Directed cases
        run_case("winner", 8'd3, 8'd7, 8'd2, 8'd5);
        run_case("tie", 8'd3, 8'd5, 8'd2, 8'd5);
        run_case("allzero", 8'd0, 8'd0, 8'd0, 8'd0);
        run_case("single", 8'd0, 8'd0, 8'd9, 8'd0);
        run_case("maxw", 8'd255, 8'd0, 8'd0, 8'd254);

        // Start held high through the run; operand change mid-run must not matter
        bus.in0 = 8'd3; bus.in1 = 8'd7; bus.in2 = 8'd2; bus.in3 = 8'd5;
        bus.start = 1'b1;
        for (cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (cyc == 3) begin
                bus.in0 = 8'd1; bus.in1 = 8'd1; bus.in2 = 8'd1; bus.in3 = 8'd1;
            end
            if (cyc == 7) begin
                chk("hold_done", 32'(bus.done), 32'd1);
                chk("hold_winner", 32'(bus.winner), 32'd1);
                chk("hold_steps", 32'(bus.steps), 32'd5);
                chk("hold_tie", 32'(bus.tie), 32'd0);
            end
        end
        tick();
        bus.start = 1'b0;
        chk("hold_reload_busy", 32'(bus.busy), 32'd1);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("hold_reload_done", 32'(bus.done), 32'd1);
        chk("hold_reload_tie", 32'(bus.tie), 32'd1);
        chk("hold_reload_steps", 32'(bus.steps), 32'd1);
        tick();

        // Reset mid-run, with start asserted alongside reset
        bus.in0 = 8'd3; bus.in1 = 8'd7; bus.in2 = 8'd2; bus.in3 = 8'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        bus.start = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_steps", 32'(bus.steps), 32'd0);
        chk("midrst_flags", 32'(zflags()), 32'hF);
        chk("midrst_winner", 32'(bus.winner), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_done", 32'(bus.done), 32'd0);
            chk("midrst_idle", 32'(bus.busy), 32'd0);
        end

        // Randomized races, biased toward shared maxima and zero lanes
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) r[i] = 8'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 3)] = 8'd0;
            if ($urandom_range(0, 3) == 0) r[1] = r[3];
            run_case("rand", r[0], r[1], r[2], r[3]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
